edge_event_arbiter_amisha: RTL and testbench

Multi-channel edge-event scheduler: detects rising edges on `N_CH` synchronous level inputs, holds each as a pending event and serialises them round-robin onto a single valid/ready event port. It sits between the per-signal edge-detect front end (buttons, status lines) and a single shared consumer such as a counter or UART reporter, replacing one `tick` wire per signal with a fair, lossless-when-drained event stream.

---
 rtl/edge_arb_pkg_amisha.sv | 11 +
 rtl/edge_pend_cell_amisha.sv | 49 ++++
 rtl/edge_event_arbiter_amisha.sv | 110 +++++++++++
 tb/tb_edge_event_arbiter_amisha.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/edge_arb_pkg_amisha.sv
// Shared types and limits for the edge-event arbiter.
package edge_arb_pkg_amisha;

  localparam int N_CH_MAX = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_e;

endpackage

// File: rtl/edge_pend_cell_amisha.sv
// One channel: previous-level register, pending event bit and optional sticky overflow.
// Optional feature: EDGE_ARB_OVF_EN adds the ovf flag.
module edge_pend_cell_amisha
  import edge_arb_pkg_amisha::*;
(
  input  logic clk,
  input  logic reset,
  input  logic level,
  input  logic enable,
  input  logic grant,
  output logic pending
`ifdef EDGE_ARB_OVF_EN
  ,
  output logic ovf
`endif
);

  logic prev;
  logic rise;

  assign rise = level & ~prev & enable;

  // NOTE: sequential state always uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    // prev tracks level even in reset so a level held high through reset is not an edge
    prev <= level;
    if (reset) begin
      pending <= 1'b0;
    end else if (!enable) begin
      pending <= 1'b0;
    end else if (rise) begin
      // a rise wins over a same-cycle grant: it is a new, separate event
      pending <= 1'b1;
    end else if (grant) begin
      pending <= 1'b0;
    end
  end

`ifdef EDGE_ARB_OVF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (rise && pending) begin
      ovf <= 1'b1;
    end
  end
`endif

endmodule

// File: rtl/edge_event_arbiter_amisha.sv
// Rising-edge detector bank feeding a round-robin valid/ready event port.
// Optional feature: EDGE_ARB_OVF_EN exposes sticky per-channel overflow flags.
module edge_event_arbiter_amisha
  import edge_arb_pkg_amisha::*;
#(
  parameter int N_CH = 4,
  parameter int ID_W = 2
) (
  input  logic            clk_amisha,
  input  logic            reset_amisha,
  input  logic [N_CH-1:0] level_amisha,
  input  logic [N_CH-1:0] enable_amisha,
  output logic            evt_valid_amisha,
  output logic [ID_W-1:0] evt_id_amisha,
  input  logic            evt_ready_amisha,
  output logic            busy_amisha
`ifdef EDGE_ARB_OVF_EN
  ,
  output logic [N_CH-1:0] ovf_amisha
`endif
);

  if (N_CH < 2 || N_CH > N_CH_MAX || (2 ** ID_W) < N_CH) begin : g_bad_params
    $error("edge_event_arbiter_amisha: unsupported N_CH/ID_W combination");
  end

  arb_state_e      state;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] next_ptr;
  logic [ID_W-1:0] base;
  logic [ID_W-1:0] winner;
  logic            found;
  logic            handshake;
  logic            load;
  logic [N_CH-1:0] pending;
  logic [N_CH-1:0] eligible;
  logic [N_CH-1:0] grant;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    edge_pend_cell_amisha u_cell (
      .clk     (clk_amisha),
      .reset   (reset_amisha),
      .level   (level_amisha[i]),
      .enable  (enable_amisha[i]),
      .grant   (grant[i]),
      .pending (pending[i])
`ifdef EDGE_ARB_OVF_EN
      ,
      .ovf     (ovf_amisha[i])
`endif
    );
  end

  // A channel being disabled this cycle loses its pending bit at this edge, so never grant it
  assign eligible  = pending & enable_amisha;
  assign handshake = (state == OFFER) & evt_ready_amisha;
  assign next_ptr  = (evt_id_amisha == ID_W'(N_CH - 1)) ? '0 : evt_id_amisha + 1'b1;
  assign base      = handshake ? next_ptr : ptr;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (!found && eligible[(int'(base) + k) % N_CH]) begin
        found  = 1'b1;
        winner = ID_W'((int'(base) + k) % N_CH);
      end
    end
  end

  assign load  = found & ((state == IDLE) | handshake);
  assign grant = load ? (N_CH'(1) << winner) : '0;

  always_ff @(posedge clk_amisha) begin
    if (reset_amisha) begin
      state            <= IDLE;
      evt_valid_amisha <= 1'b0;
      evt_id_amisha    <= '0;
      ptr              <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            evt_id_amisha    <= winner;
            evt_valid_amisha <= 1'b1;
            state            <= OFFER;
          end
        end
        OFFER: begin
          if (handshake) begin
            ptr <= next_ptr;
            if (load) begin
              evt_id_amisha <= winner;
            end else begin
              evt_valid_amisha <= 1'b0;
              state            <= IDLE;
            end
          end
        end
        default: begin
          state            <= IDLE;
          evt_valid_amisha <= 1'b0;
        end
      endcase
    end
  end

  assign busy_amisha = evt_valid_amisha | (|pending);

endmodule

// File: tb/tb_edge_event_arbiter_amisha.sv
// Self-checking bench: directed scenarios with literal expectations plus a randomized run against an event-level model.
module tb_edge_event_arbiter_amisha;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] level;
  logic [N-1:0] enable;
  logic         ready;
  logic         evt_valid;
  logic [1:0]   evt_id;
  logic         busy;
`ifdef EDGE_ARB_OVF_EN
  logic [N-1:0] ovf;
`endif

  int passed = 0;
  int total  = 0;

  edge_event_arbiter_amisha #(.N_CH(N), .ID_W(2)) dut (
    .clk_amisha       (clk),
    .reset_amisha     (reset),
    .level_amisha     (level),
    .enable_amisha    (enable),
    .evt_valid_amisha (evt_valid),
    .evt_id_amisha    (evt_id),
    .evt_ready_amisha (ready),
    .busy_amisha      (busy)
`ifdef EDGE_ARB_OVF_EN
    ,
    .ovf_amisha       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  // Reference model: per-channel pending events, one output slot, rotating search start.
  bit       m_init = 0;
  bit [N-1:0] m_prev, m_pend, m_ovf;
  bit       m_valid;
  int       m_id, m_ptr;

  always @(posedge clk) begin : model
    bit hs, found, load, rise;
    int w, c;
    if (reset) begin
      m_pend = '0; m_ovf = '0; m_valid = 0; m_id = 0; m_ptr = 0; m_init = 1;
    end else if (m_init) begin
      hs = m_valid && ready;
      if (hs) m_ptr = (m_id + 1) % N;
      found = 0; w = 0;
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (!found && m_pend[c] && enable[c]) begin found = 1; w = c; end
      end
      load = found && (!m_valid || hs);
      for (int i = 0; i < N; i++) begin
        rise = level[i] && !m_prev[i] && enable[i];
        if (rise && m_pend[i]) m_ovf[i] = 1;
        if (!enable[i])             m_pend[i] = 0;
        else if (rise)              m_pend[i] = 1;
        else if (load && w == i)    m_pend[i] = 0;
      end
      if (load) begin m_valid = 1; m_id = w; end
      else if (hs) m_valid = 0;
    end
    m_prev = level;
  end

  always @(negedge clk) begin
    if (m_init) begin
      check("model_valid", evt_valid, m_valid);
      check("model_id", evt_id, m_id);
      check("model_busy", busy, m_valid || (m_pend != 0));
`ifdef EDGE_ARB_OVF_EN
      check("model_ovf", ovf, m_ovf);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic expect_evt(input string name, input logic v, input logic [1:0] id);
    check({name, "_valid"}, evt_valid, v);
    if (v) check({name, "_id"}, evt_id, id);
  endtask

  initial begin
    reset = 1'b1; level = 4'b0101; enable = 4'hF; ready = 1'b1;

    // Level held high through reset must not produce events
    do_reset();
    check("rst_valid", evt_valid, 1'b0);
    check("rst_id", evt_id, 2'd0);
    check("rst_busy", busy, 1'b0);
    for (int i = 0; i < 10; i++) check("no_evt_after_rst", evt_valid, 1'b0);

    // Single rise on ch2: one-cycle-wide event two edges later
    level = 4'b0000; do_reset();
    level = 4'b0100;
    tick(); expect_evt("ch2_lat1", 1'b0, 2'd0);
    tick(); expect_evt("ch2_offer", 1'b1, 2'd2);
    tick(); expect_evt("ch2_done", 1'b0, 2'd0);

    // Simultaneous rises from ptr=0
    level = 4'b0000; do_reset();
    level = 4'b1111;
    tick();
    for (int i = 0; i < 4; i++) begin tick(); expect_evt("rr_from0", 1'b1, 2'(i)); end
    tick(); expect_evt("rr_from0_end", 1'b0, 2'd0);

    // After ch1 was last granted, order is 2,3,0,1
    level = 4'b0000; do_reset();
    level = 4'b0010; tick(); tick(); expect_evt("ch1_first", 1'b1, 2'd1);
    level = 4'b0000; tick(); expect_evt("ch1_gone", 1'b0, 2'd0);
    level = 4'b1111; tick();
    for (int i = 0; i < 4; i++) begin tick(); expect_evt("rr_from2", 1'b1, 2'((i + 2) % 4)); end

    // Backpressure: ch1 held while ch3 waits
    level = 4'b0000; ready = 1'b0; do_reset();
    level = 4'b0010; tick(); tick(); expect_evt("hold_a", 1'b1, 2'd1);
    level = 4'b1010; tick(); expect_evt("hold_b", 1'b1, 2'd1);
    tick(); expect_evt("hold_c", 1'b1, 2'd1);
    ready = 1'b1; tick(); expect_evt("after_hold", 1'b1, 2'd3);
    tick(); expect_evt("after_hold_end", 1'b0, 2'd0);

    // Two rises on pending ch0 merge into one event
    level = 4'b0000; ready = 1'b0; do_reset();
    level = 4'b0010; tick(); tick(); expect_evt("merge_slot", 1'b1, 2'd1);
    level = 4'b0011; tick();
    level = 4'b0010; tick();
    level = 4'b0011; tick();
`ifdef EDGE_ARB_OVF_EN
    check("ovf_ch0", ovf, 4'b0001);
`endif
    ready = 1'b1; tick(); expect_evt("merge_ch0", 1'b1, 2'd0);
    tick(); expect_evt("merge_single", 1'b0, 2'd0);
    check("merge_busy", busy, 1'b0);

    // Reset during an offer drops it
    level = 4'b0000; ready = 1'b0; do_reset();
    level = 4'b0010; tick(); tick(); expect_evt("pre_rst", 1'b1, 2'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    check("mid_rst_valid", evt_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);

    // Disabling a pending channel discards its event
    level = 4'b0000; ready = 1'b0; do_reset();
    level = 4'b0010; tick(); tick(); expect_evt("dis_slot", 1'b1, 2'd1);
    level = 4'b0110; tick(); check("dis_busy", busy, 1'b1);
    enable = 4'b1011; tick();
    ready = 1'b1; tick(); expect_evt("dis_none", 1'b0, 2'd0);
    check("dis_idle", busy, 1'b0);
    enable = 4'hF;

    // Randomized run; the model compare process checks every cycle
    for (int i = 0; i < 3000; i++) begin
      level  = 4'($urandom_range(0, 15));
      enable = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      ready  = ($urandom_range(0, 3) != 0);
      reset  = ($urandom_range(0, 149) == 0);
      tick();
    end
    reset = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
